// File: rtl/ovc_status_alloc.sv
// Output VC status tracking and round-robin allocation with per-VC credit counters.
// Define OVC_ALLOC_ERR_CHECK_EN to build the sticky credit overflow/underflow detector on err.
module ovc_status_alloc #(
    parameter int V = 4,
    parameter int B = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic [V-1:0] ovc_mask,
    input  logic [V-1:0] flit_sent,
    input  logic [V-1:0] tail_sent,
    input  logic [V-1:0] credit_in,
    output logic         grant_valid,
    output logic [V-1:0] grant_ovc,
    output logic [V-1:0] ovc_allocated,
    output logic [V-1:0] ovc_full,
    output logic         err
);

    localparam int Bw = $clog2(B + 1);
    localparam int PW = (V > 1) ? $clog2(V) : 1;

    logic [Bw-1:0] credit_cnt [V];
    logic [V-1:0]  allocated_q;
    logic [PW-1:0] rr_ptr;

    logic [V-1:0]  cnt_dec;
    logic [V-1:0]  cnt_inc;
    logic [V-1:0]  at_max;
    logic [V-1:0]  eligible;

    logic          pick_found;
    logic [PW-1:0] pick_idx;
    logic [PW:0]   search_sum;
    logic [PW-1:0] search_idx;
    logic [V-1:0]  pick_onehot;
    logic          do_grant;

    // Simultaneous send and credit return cancel out, so only one-sided events move a counter.
    always_comb begin
        cnt_dec  = flit_sent & ~credit_in;
        cnt_inc  = credit_in & ~flit_sent;
        ovc_full = '0;
        at_max   = '0;
        for (int i = 0; i < V; i++) begin
            ovc_full[i] = (credit_cnt[i] == '0);
            at_max[i]   = (credit_cnt[i] == Bw'(B));
        end
    end

    assign eligible      = ovc_mask & ~allocated_q & ~ovc_full;
    assign ovc_allocated = allocated_q;

    // Search upward from the pointer with wrap-around; first eligible VC wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        search_sum = '0;
        search_idx = '0;
        for (int off = 0; off < V; off++) begin
            search_sum = {1'b0, rr_ptr} + (PW + 1)'(off);
            if (search_sum >= (PW + 1)'(V)) begin
                search_sum = search_sum - (PW + 1)'(V);
            end
            search_idx = search_sum[PW-1:0];
            if (!pick_found && eligible[search_idx]) begin
                pick_found = 1'b1;
                pick_idx   = search_idx;
            end
        end
    end

    assign do_grant    = req & pick_found;
    assign pick_onehot = do_grant ? ({{(V - 1){1'b0}}, 1'b1} << pick_idx) : '0;

    // Counters saturate at 0 and B; out-of-range events are dropped rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < V; i++) begin
                credit_cnt[i] <= Bw'(B);
            end
        end else begin
            for (int i = 0; i < V; i++) begin
                if (cnt_dec[i] && !ovc_full[i]) begin
                    credit_cnt[i] <= credit_cnt[i] - Bw'(1);
                end else if (cnt_inc[i] && !at_max[i]) begin
                    credit_cnt[i] <= credit_cnt[i] + Bw'(1);
                end
            end
        end
    end

    // The granted VC is never currently allocated, so release and grant cannot collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_valid <= 1'b0;
            grant_ovc   <= '0;
            allocated_q <= '0;
            rr_ptr      <= '0;
        end else begin
            grant_valid <= do_grant;
            grant_ovc   <= pick_onehot;
            allocated_q <= (allocated_q & ~tail_sent) | pick_onehot;
            if (do_grant) begin
                if (pick_idx == PW'(V - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= pick_idx + PW'(1);
                end
            end
        end
    end

`ifdef OVC_ALLOC_ERR_CHECK_EN
    logic err_q;
    logic [V-1:0] underflow;
    logic [V-1:0] overflow;

    assign underflow = cnt_dec & ovc_full;
    assign overflow  = cnt_inc & at_max;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (|underflow || |overflow) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
